// File: rtl/chara_pkg.sv
// chara_pkg -- shared definitions for the character motion controller.
//
// Holds the motion-state encoding (as plain constants and as the enum
// built from them) plus a small helper that classifies airborne states.
// Imported by chara_motion_ctrl and chara_anim_ctr.

package chara_pkg;

  // Motion-state encoding; o_state exposes these raw values.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_WALK_ENC = 2'd1;
  localparam logic [1:0] ST_JUMP_ENC = 2'd2;
  localparam logic [1:0] ST_FALL_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_WALK = ST_WALK_ENC,
    ST_JUMP = ST_JUMP_ENC,
    ST_FALL = ST_FALL_ENC
  } motion_state_t;

  // True for the two states where the sprite is off the ground.
  function automatic logic is_airborne(input motion_state_t s);
    return (s == ST_JUMP) || (s == ST_FALL);
  endfunction

endpackage

// File: rtl/chara_anim_ctr.sv
// chara_anim_ctr -- sprite animation frame index for the motion controller.
//
// Ports:
//   clk        pixel clock
//   rst_n      synchronous active-low reset
//   frame      one-cycle start-of-frame pulse; the only update strobe
//   state      current motion state (registered)
//   state_nxt  motion state being committed on this frame pulse
//   anim       sprite frame index (registered)
//
// IDLE shows frame 0, airborne states show the last frame, WALK cycles
// 0..SPR_FRAMES-2 advancing once every ANIM_DIV frame pulses. The divider
// restarts whenever the state changes, so a fresh walk always starts on 0.

module chara_anim_ctr
  import chara_pkg::*;
#(
  parameter int SPR_FRAMES = 3,
  parameter int ANIM_DIV   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame,
  input  motion_state_t state,
  input  motion_state_t state_nxt,
  output logic [1:0]    anim
);

  localparam int             DIVW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(ANIM_DIV - 1);
  localparam logic [1:0]     WRAP_AT   = 2'(SPR_FRAMES - 2);
  localparam logic [1:0]     AIR_FRAME = 2'(SPR_FRAMES - 1);

  logic [DIVW-1:0] div;
  logic [DIVW-1:0] div_nxt;
  logic [1:0]      anim_nxt;

  // Next divider / frame index, evaluated against the state being entered.
  always_comb begin
    div_nxt  = '0;
    anim_nxt = anim;
    case (state_nxt)
      ST_WALK: begin
        if (state != ST_WALK) begin
          div_nxt  = '0;
          anim_nxt = 2'd0;
        end else if (div == DIV_LAST) begin
          div_nxt  = '0;
          anim_nxt = (anim >= WRAP_AT) ? 2'd0 : anim + 2'd1;
        end else begin
          div_nxt  = div + DIVW'(1);
          anim_nxt = anim;
        end
      end
      ST_JUMP, ST_FALL: begin
        div_nxt  = '0;
        anim_nxt = is_airborne(state_nxt) ? AIR_FRAME : 2'd0;
      end
      ST_IDLE: begin
        div_nxt  = '0;
        anim_nxt = 2'd0;
      end
      default: begin
        div_nxt  = '0;
        anim_nxt = 2'd0;
      end
    endcase
  end

  // Divider and frame-index registers, updated only on frame pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div  <= '0;
      anim <= 2'd0;
    end else if (frame) begin
      div  <= div_nxt;
      anim <= anim_nxt;
    end else begin
      div  <= div;
      anim <= anim;
    end
  end

endmodule

// File: rtl/chara_motion_ctrl.sv
// chara_motion_ctrl -- per-frame motion controller for a side-view sprite.
//
// Ports:
//   i_clk_pix      pixel clock (only clock)
//   i_rst_n        synchronous active-low reset, wins over i_frame
//   i_frame        one-cycle start-of-frame pulse; state changes only here
//   i_ctrl         {jump, left, right} key levels
//   o_x, o_y       signed sprite top-left position
//   o_anim         sprite frame index (from chara_anim_ctr)
//   o_facing_left  horizontal mirror request
//   o_state        motion state (IDLE/WALK/JUMP/FALL encoding of chara_pkg)
//
// Build option: define CHARA_DOUBLE_JUMP_EN to allow one extra jump while
// airborne per landing. Without it the credit register does not exist.
//
// Vertical arithmetic is carried one bit wider than CORDW so the sums used
// for the ceiling/ground tests cannot wrap before they are compared.

module chara_motion_ctrl
  import chara_pkg::*;
#(
  parameter int CORDW      = 16,
  parameter int H_RES      = 800,
  parameter int SPR_W      = 76,
  parameter int GROUND_Y   = 400,
  parameter int X_START    = 0,
  parameter int WALK_SPEED = 4,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 15,
  parameter int SPR_FRAMES = 3,
  parameter int ANIM_DIV   = 8
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_frame,
  input  logic [2:0]              i_ctrl,
  output logic signed [CORDW-1:0] o_x,
  output logic signed [CORDW-1:0] o_y,
  output logic [1:0]              o_anim,
  output logic                    o_facing_left,
  output logic [1:0]              o_state
);

  localparam int SW = CORDW + 1;

  localparam logic signed [SW-1:0]    WALK_S     = SW'(WALK_SPEED);
  localparam logic signed [SW-1:0]    XMAX_S     = SW'(H_RES - SPR_W);
  localparam logic signed [SW-1:0]    GROUND_S   = SW'(GROUND_Y);
  localparam logic signed [SW-1:0]    GRAV_S     = SW'(GRAVITY);
  localparam logic signed [SW-1:0]    MAXF_S     = SW'(MAX_FALL);
  localparam logic signed [CORDW-1:0] XMAX_C     = CORDW'(H_RES - SPR_W);
  localparam logic signed [CORDW-1:0] X_RST      = CORDW'(X_START);
  localparam logic signed [CORDW-1:0] Y_GROUND   = CORDW'(GROUND_Y);
  localparam logic signed [CORDW-1:0] MAXF_C     = CORDW'(MAX_FALL);
  localparam logic signed [CORDW-1:0] TAKEOFF_VY = CORDW'(-JUMP_VEL);

  motion_state_t           state;
  motion_state_t           state_nxt;
  logic signed [CORDW-1:0] x, y, vy;
  logic signed [CORDW-1:0] x_nxt, y_nxt, vy_nxt;
  logic                    facing;
  logic                    facing_nxt;

  logic                    jump, go_left, move, air_jump;
  logic signed [SW-1:0]    x_ext, y_ext, vy_ext;
  logic signed [SW-1:0]    x_step, y_sum, vy_grav;

  assign jump    = i_ctrl[2];
  assign go_left = i_ctrl[1];
  assign move    = i_ctrl[1] ^ i_ctrl[0];

`ifdef CHARA_DOUBLE_JUMP_EN
  logic credit;
  logic credit_nxt;
  assign air_jump = jump & credit;
`else
  assign air_jump = 1'b0;
`endif

  // Next position, velocity, facing and state for the coming frame pulse.
  always_comb begin
    x_nxt      = x;
    y_nxt      = y;
    vy_nxt     = vy;
    state_nxt  = state;
    facing_nxt = facing;
`ifdef CHARA_DOUBLE_JUMP_EN
    credit_nxt = credit;
`endif
    x_ext   = {x[CORDW-1], x};
    y_ext   = {y[CORDW-1], y};
    vy_ext  = {vy[CORDW-1], vy};
    x_step  = '0;
    y_sum   = y_ext + vy_ext;
    vy_grav = vy_ext + GRAV_S;

    // Horizontal move applies in every state; facing follows the key even
    // when the clamp leaves x where it was.
    if (move) begin
      facing_nxt = go_left;
      if (go_left) begin
        x_step = x_ext - WALK_S;
        if (x_step[SW-1]) begin
          x_nxt = '0;
        end else begin
          x_nxt = x_step[CORDW-1:0];
        end
      end else begin
        x_step = x_ext + WALK_S;
        if (x_step > XMAX_S) begin
          x_nxt = XMAX_C;
        end else begin
          x_nxt = x_step[CORDW-1:0];
        end
      end
    end else begin
      facing_nxt = facing;
    end

    case (state)
      ST_IDLE, ST_WALK: begin
        // Takeoff frame: velocity is loaded, height moves from next frame.
        if (jump) begin
          state_nxt = ST_JUMP;
          vy_nxt    = TAKEOFF_VY;
        end else if (move) begin
          state_nxt = ST_WALK;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_JUMP: begin
        if (air_jump) begin
          state_nxt = ST_JUMP;
          vy_nxt    = TAKEOFF_VY;
`ifdef CHARA_DOUBLE_JUMP_EN
          credit_nxt = 1'b0;
`endif
        end else if (y_sum[SW-1]) begin
          // Would pass the top of the screen: pin to row 0 and drop.
          y_nxt     = '0;
          vy_nxt    = '0;
          state_nxt = ST_FALL;
        end else begin
          y_nxt  = y_sum[CORDW-1:0];
          vy_nxt = vy_grav[CORDW-1:0];
          if (!vy_grav[SW-1]) begin
            state_nxt = ST_FALL;
          end else begin
            state_nxt = ST_JUMP;
          end
        end
      end
      ST_FALL: begin
        if (air_jump) begin
          state_nxt = ST_JUMP;
          vy_nxt    = TAKEOFF_VY;
`ifdef CHARA_DOUBLE_JUMP_EN
          credit_nxt = 1'b0;
`endif
        end else if (y_sum >= GROUND_S) begin
          y_nxt     = Y_GROUND;
          vy_nxt    = '0;
          state_nxt = move ? ST_WALK : ST_IDLE;
`ifdef CHARA_DOUBLE_JUMP_EN
          credit_nxt = 1'b1;
`endif
        end else begin
          y_nxt = y_sum[CORDW-1:0];
          if (vy_grav > MAXF_S) begin
            vy_nxt = MAXF_C;
          end else begin
            vy_nxt = vy_grav[CORDW-1:0];
          end
          state_nxt = ST_FALL;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Motion registers: reset wins, otherwise update on frame pulses only.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      x      <= X_RST;
      y      <= Y_GROUND;
      vy     <= '0;
      state  <= ST_IDLE;
      facing <= 1'b0;
    end else if (i_frame) begin
      x      <= x_nxt;
      y      <= y_nxt;
      vy     <= vy_nxt;
      state  <= state_nxt;
      facing <= facing_nxt;
    end else begin
      x      <= x;
      y      <= y;
      vy     <= vy;
      state  <= state;
      facing <= facing;
    end
  end

`ifdef CHARA_DOUBLE_JUMP_EN
  // Air-jump credit: granted at reset and on every landing.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      credit <= 1'b1;
    end else if (i_frame) begin
      credit <= credit_nxt;
    end else begin
      credit <= credit;
    end
  end
`endif

  chara_anim_ctr #(
    .SPR_FRAMES (SPR_FRAMES),
    .ANIM_DIV   (ANIM_DIV)
  ) u_anim (
    .clk       (i_clk_pix),
    .rst_n     (i_rst_n),
    .frame     (i_frame),
    .state     (state),
    .state_nxt (state_nxt),
    .anim      (o_anim)
  );

  assign o_x           = x;
  assign o_y           = y;
  assign o_facing_left = facing;
  assign o_state       = state;

endmodule

// File: tb/tb_chara_motion_ctrl.sv
// tb_chara_motion_ctrl -- self-checking bench for chara_motion_ctrl.
//
// A directed table of {inputs, expected outputs} rows walks through reset,
// walking, clamping, the animation cadence and a full jump arc; a few hand
// sequences cover hold-without-frame, a second instance started at x=722
// and airborne jumps; then randomized key traffic is compared against a
// frame-level reference model. Follows CHARA_DOUBLE_JUMP_EN when defined.

module tb_chara_motion_ctrl;

  localparam int XMAX = 724;
  localparam int GY   = 400;
  localparam int WS   = 4;
  localparam int JV   = 12;
  localparam int GR   = 1;
  localparam int MF   = 15;
  localparam int NF   = 3;
  localparam int AD   = 8;
`ifdef CHARA_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              frame;
  logic [2:0]        ctrl;
  logic signed [15:0] o_x, o_y, o2_x, o2_y;
  logic [1:0]        o_anim, o_state, o2_anim, o2_state;
  logic              o_face, o2_face;

  chara_motion_ctrl dut (
    .i_clk_pix     (clk),
    .i_rst_n       (rst_n),
    .i_frame       (frame),
    .i_ctrl        (ctrl),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_anim        (o_anim),
    .o_facing_left (o_face),
    .o_state       (o_state)
  );

  chara_motion_ctrl #(.X_START(722)) dut2 (
    .i_clk_pix     (clk),
    .i_rst_n       (rst_n),
    .i_frame       (frame),
    .i_ctrl        (ctrl),
    .o_x           (o2_x),
    .o_y           (o2_y),
    .o_anim        (o2_anim),
    .o_facing_left (o2_face),
    .o_state       (o2_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (state numbers: 0 idle, 1 walk, 2 jump, 3 fall).
  int mx, my, mvy, mst, mface, mwc, manim;
  bit mcred;

  typedef struct {
    string      name;
    bit         rst;
    int         n;
    logic [2:0] c;
    int         ex, ey, est, ean, efc;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string nm, input bit r, input int n, input logic [2:0] c,
                     input int ex, input int ey, input int est, input int ean, input int efc);
    vec_t v;
    v.name = nm; v.rst = r; v.n = n; v.c = c;
    v.ex = ex; v.ey = ey; v.est = est; v.ean = ean; v.efc = efc;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input logic [2:0] c, input logic fr);
    @(negedge clk);
    rst_n = 1'b0; frame = fr; ctrl = c;
    @(negedge clk);
    rst_n = 1'b1; frame = 1'b0; ctrl = 3'b000;
  endtask

  task automatic pulse(input logic [2:0] c);
    @(negedge clk);
    ctrl = c; frame = 1'b1;
    @(negedge clk);
    frame = 1'b0;
  endtask

  task automatic check(input string nm, input int ex, input int ey, input int est,
                       input int ean, input int efc);
    n_vec++;
    if (o_x !== 16'(ex) || o_y !== 16'(ey) || o_state !== 2'(est) ||
        o_anim !== 2'(ean) || o_face !== 1'(efc)) begin
      n_err++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d anim=%0d face=%0d, want x=%0d y=%0d st=%0d anim=%0d face=%0d",
               nm, o_x, o_y, o_state, o_anim, o_face, ex, ey, est, ean, efc);
    end
  endtask

  task automatic check2(input string nm, input int ex, input int ey, input int est,
                        input int ean, input int efc);
    n_vec++;
    if (o2_x !== 16'(ex) || o2_y !== 16'(ey) || o2_state !== 2'(est) ||
        o2_anim !== 2'(ean) || o2_face !== 1'(efc)) begin
      n_err++;
      $display("FAIL %s: got x=%0d y=%0d st=%0d anim=%0d face=%0d, want x=%0d y=%0d st=%0d anim=%0d face=%0d",
               nm, o2_x, o2_y, o2_state, o2_anim, o2_face, ex, ey, est, ean, efc);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = GY; mvy = 0; mst = 0; mface = 0; mwc = 0; manim = 0; mcred = 1'b1;
  endtask

  // One frame of the motion rules, in plain integer arithmetic.
  task automatic model_pulse(input logic [2:0] c);
    bit j, l, mv;
    int prev;
    j = c[2]; l = c[1]; mv = c[1] ^ c[0];
    if (mv) begin
      if (l) mx = (mx - WS < 0) ? 0 : mx - WS;
      else   mx = (mx + WS > XMAX) ? XMAX : mx + WS;
      mface = l;
    end
    prev = mst;
    if (mst <= 1) begin
      if (j) begin mst = 2; mvy = -JV; end
      else mst = mv ? 1 : 0;
    end else if (DJ && j && mcred) begin
      mvy = -JV; mst = 2; mcred = 1'b0;
    end else if (mst == 2) begin
      if (my + mvy < 0) begin my = 0; mvy = 0; mst = 3; end
      else begin
        my = my + mvy; mvy = mvy + GR;
        if (mvy >= 0) mst = 3;
      end
    end else begin
      if (my + mvy >= GY) begin
        my = GY; mvy = 0; mst = mv ? 1 : 0; mcred = 1'b1;
      end else begin
        my = my + mvy;
        mvy = (mvy + GR > MF) ? MF : mvy + GR;
      end
    end
    // Walk frame = number of frames spent in WALK since entering it.
    if (mst == 1) begin
      mwc = (prev == 1) ? mwc + 1 : 0;
      manim = (mwc / AD) % (NF - 1);
    end else if (mst == 0) begin
      manim = 0;
    end else begin
      manim = NF - 1;
    end
  endtask

  initial begin
    logic [2:0] c;
    int dir;
    rst_n = 1'b1; frame = 1'b0; ctrl = 3'b000;

    // Second instance starts at x=722: one right step clamps to 724.
    do_reset(3'b000, 1'b0);
    pulse(3'b001); check2("x722_right", 724, GY, 1, 0, 0);
    pulse(3'b011); check2("x724_both", 724, GY, 0, 0, 0);

    //  name            rst  n    ctrl    x    y  st an fc
    add("reset",        1,   0,   3'b001, 0,   GY, 0, 0, 0);
    add("idle10",       0,   10,  3'b000, 0,   GY, 0, 0, 0);
    add("left_clamp",   0,   3,   3'b010, 0,   GY, 1, 0, 1);
    add("stop",         0,   1,   3'b000, 0,   GY, 0, 0, 1);
    add("right8",       0,   8,   3'b001, 32,  GY, 1, 0, 0);
    add("right16",      0,   8,   3'b001, 64,  GY, 1, 1, 0);
    add("right24",      0,   8,   3'b001, 96,  GY, 1, 0, 0);
    add("right_clamp",  0,   160, 3'b001, 724, GY, 1, 0, 0);
    add("both_keys",    0,   1,   3'b011, 724, GY, 0, 0, 0);
    add("takeoff",      0,   1,   3'b100, 724, GY, 2, 2, 0);
    add("rise11",       0,   11,  3'b000, 724, 323, 2, 2, 0);
    add("apex",         0,   1,   3'b000, 724, 322, 3, 2, 0);
    add("fall12",       0,   12,  3'b000, 724, 388, 3, 2, 0);
    add("land",         0,   1,   3'b000, 724, GY, 0, 0, 0);
    add("jump_left",    0,   1,   3'b110, 720, GY, 2, 2, 1);
    add("air_left",     0,   5,   3'b010, 700, 350, 2, 2, 1);
    add("reset_midair", 1,   0,   3'b101, 0,   GY, 0, 0, 0);
    add("walk_after",   0,   1,   3'b001, 4,   GY, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset(tbl[i].c, 1'b1);
      else repeat (tbl[i].n) pulse(tbl[i].c);
      check(tbl[i].name, tbl[i].ex, tbl[i].ey, tbl[i].est, tbl[i].ean, tbl[i].efc);
    end

    // Keys change without a frame pulse: nothing may move.
    repeat (6) begin
      @(negedge clk);
      ctrl = 3'($urandom_range(0, 7));
    end
    check("hold_no_frame", 4, GY, 1, 0, 0);

    // Airborne jump handling.
    do_reset(3'b000, 1'b0);
    pulse(3'b100);
`ifdef CHARA_DOUBLE_JUMP_EN
    repeat (3) pulse(3'b000);
    check("rise3", 0, 367, 2, 2, 0);
    pulse(3'b100); check("second_jump", 0, 367, 2, 2, 0);
    pulse(3'b000); check("second_rise", 0, 355, 2, 2, 0);
    pulse(3'b100); check("third_ignored", 0, 344, 2, 2, 0);
`else
    repeat (3) pulse(3'b100);
    check("air_jump_ignored", 0, 367, 2, 2, 0);
`endif

    // Randomized traffic against the reference model.
    do_reset(3'b000, 1'b0);
    model_reset();
    check("rand_reset", mx, my, mst, manim, mface);
    dir = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(3'($urandom_range(0, 7)), 1'b1);
        model_reset();
        check("rand_reset_mid", mx, my, mst, manim, mface);
      end else begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          ctrl = 3'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 15) == 0) dir = $urandom_range(0, 3);
        c[1:0] = 2'(dir);
        c[2]   = ($urandom_range(0, 7) == 0);
        pulse(c);
        model_pulse(c);
        check("rand_pulse", mx, my, mst, manim, mface);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
